// File: rtl/decode_stage_pipe.sv
// Pipelined decode stage: register file, immediate generator, control decode and one output
// register with valid/ready, write bypass, load-use stall and flush. Optional macro: DEC_ILLEGAL_EN.
module decode_stage_pipe #(
  parameter int XLEN  = 64,
  parameter int NREGS = 32,
  localparam int AW   = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     Instr,
  input  logic [XLEN-1:0] in_pc,
  input  logic            flush,
  input  logic            wb_en,
  input  logic [AW-1:0]   wb_addr,
  input  logic [XLEN-1:0] wb_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] ReadData1,
  output logic [XLEN-1:0] ReadData2,
  output logic [XLEN-1:0] ImmExt,
  output logic [AW-1:0]   Rd,
  output logic            Branch,
  output logic            MemRead,
  output logic            MemtoReg,
  output logic            MemWrite,
  output logic            ALUSrc,
  output logic            RegWrite,
  output logic [3:0]      ALUOp
`ifdef DEC_ILLEGAL_EN
  ,
  output logic            Illegal
`endif
);

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_ADDI = 7'b0010011;
  localparam logic [6:0] OP_LD   = 7'b0000011;
  localparam logic [6:0] OP_SD   = 7'b0100011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;

`ifdef DEC_ILLEGAL_EN
  localparam bit ILL_EN = 1'b1;
`else
  localparam bit ILL_EN = 1'b0;
`endif

  typedef enum logic {S_EMPTY = 1'b0, S_FULL = 1'b1} state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [XLEN-1:0] r_rf [NREGS];

  logic [XLEN-1:0] r_pc, r_rd1, r_rd2, r_imm;
  logic [AW-1:0]   r_rd;
  logic            r_branch, r_memread, r_memtoreg, r_memwrite, r_alusrc, r_regwrite;
  logic [3:0]      r_aluop;
  logic            r_shadow_v;
  logic [AW-1:0]   r_shadow_rd;
`ifdef DEC_ILLEGAL_EN
  logic            r_illegal;
`endif

  logic [6:0]      w_opcode;
  logic [2:0]      w_funct3;
  logic            w_f7b5;
  logic [AW-1:0]   w_rs1, w_rs2, w_rd;
  logic [11:0]     w_imm_i, w_imm_s;
  logic [12:0]     w_imm_b;
  logic [XLEN-1:0] w_imm;
  logic            w_branch, w_memread, w_memtoreg, w_memwrite, w_alusrc, w_regwrite;
  logic [3:0]      w_aluop;
  logic            w_illegal, w_use_rs1, w_use_rs2;
  logic [XLEN-1:0] w_rd1, w_rd2;
  logic            w_hz_out, w_hz_shadow, w_hazard, w_advance, w_accept;

  assign w_opcode = Instr[6:0];
  assign w_funct3 = Instr[14:12];
  assign w_f7b5   = Instr[30];
  assign w_rs1    = Instr[15 +: AW];
  assign w_rs2    = Instr[20 +: AW];
  assign w_imm_i  = Instr[31:20];
  assign w_imm_s  = {Instr[31:25], Instr[11:7]};
  assign w_imm_b  = {Instr[31], Instr[7], Instr[30:25], Instr[11:8], 1'b0};

  // Control and immediate decode of the presented instruction.
  always_comb begin
    w_branch   = 1'b0;
    w_memread  = 1'b0;
    w_memtoreg = 1'b0;
    w_memwrite = 1'b0;
    w_alusrc   = 1'b0;
    w_regwrite = 1'b0;
    w_aluop    = 4'b0000;
    w_imm      = '0;
    w_rd       = Instr[7 +: AW];
    w_illegal  = 1'b0;
    w_use_rs1  = 1'b0;
    w_use_rs2  = 1'b0;
    case (w_opcode)
      OP_R: begin
        w_use_rs1  = 1'b1;
        w_use_rs2  = 1'b1;
        w_regwrite = 1'b1;
        case ({w_funct3, w_f7b5})
          4'b000_0: w_aluop = 4'b0010;
          4'b000_1: w_aluop = 4'b0110;
          4'b111_0: w_aluop = 4'b0111;
          4'b110_0: w_aluop = 4'b0001;
          default: begin
            w_aluop   = 4'b0000;
            w_illegal = 1'b1;
          end
        endcase
      end
      OP_ADDI: begin
        if (w_funct3 == 3'b000) begin
          w_use_rs1  = 1'b1;
          w_alusrc   = 1'b1;
          w_regwrite = 1'b1;
          w_aluop    = 4'b0010;
          w_imm      = {{(XLEN-12){w_imm_i[11]}}, w_imm_i};
        end else begin
          w_illegal  = 1'b1;
        end
      end
      OP_LD: begin
        w_use_rs1  = 1'b1;
        w_alusrc   = 1'b1;
        w_memread  = 1'b1;
        w_memtoreg = 1'b1;
        w_regwrite = 1'b1;
        w_aluop    = 4'b0010;
        w_imm      = {{(XLEN-12){w_imm_i[11]}}, w_imm_i};
      end
      OP_SD: begin
        w_use_rs1  = 1'b1;
        w_use_rs2  = 1'b1;
        w_alusrc   = 1'b1;
        w_memwrite = 1'b1;
        w_imm      = {{(XLEN-12){w_imm_s[11]}}, w_imm_s};
        w_rd       = '0;
      end
      OP_BEQ: begin
        w_use_rs1  = 1'b1;
        w_use_rs2  = 1'b1;
        w_branch   = 1'b1;
        w_aluop    = 4'b0110;
        w_imm      = {{(XLEN-13){w_imm_b[12]}}, w_imm_b};
        w_rd       = '0;
      end
      default: begin
        w_illegal  = 1'b1;
      end
    endcase
    // An illegal instruction travels with every control deasserted.
    if (ILL_EN && w_illegal) begin
      w_regwrite = 1'b0;
      w_aluop    = 4'b0000;
    end else begin
      w_aluop    = w_aluop;
    end
  end

  // Operand read: x0 is zero, a same-cycle writeback to the source wins over the array.
  always_comb begin
    if (w_rs1 == '0) begin
      w_rd1 = '0;
    end else if (wb_en && (wb_addr == w_rs1)) begin
      w_rd1 = wb_data;
    end else begin
      w_rd1 = r_rf[w_rs1];
    end
    if (w_rs2 == '0) begin
      w_rd2 = '0;
    end else if (wb_en && (wb_addr == w_rs2)) begin
      w_rd2 = wb_data;
    end else begin
      w_rd2 = r_rf[w_rs2];
    end
  end

  // Load-use detection against the bundle in the out register and the one-cycle shadow.
  assign w_hz_out = out_valid && r_memread && (r_rd != '0) &&
                    ((w_use_rs1 && (w_rs1 == r_rd)) || (w_use_rs2 && (w_rs2 == r_rd)));
  assign w_hz_shadow = r_shadow_v && (r_shadow_rd != '0) &&
                       ((w_use_rs1 && (w_rs1 == r_shadow_rd)) || (w_use_rs2 && (w_rs2 == r_shadow_rd)));
  assign w_hazard  = in_valid && (w_hz_out || w_hz_shadow);
  assign w_advance = !out_valid || out_ready;
  assign in_ready  = w_advance && !w_hazard && !flush;
  assign w_accept  = in_valid && in_ready;

  // Register file storage; x0 is never written.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREGS; i++) r_rf[i] <= '0;
    end else if (wb_en && (wb_addr != '0)) begin
      r_rf[wb_addr] <= wb_data;
    end
  end

  // Occupancy state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_EMPTY;
    else        r_state <= w_state_nxt;
  end

  // Occupancy next state; flush always empties the out register.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_EMPTY: begin
        if (flush)         w_state_nxt = S_EMPTY;
        else if (w_accept) w_state_nxt = S_FULL;
        else               w_state_nxt = S_EMPTY;
      end
      S_FULL: begin
        if (flush)          w_state_nxt = S_EMPTY;
        else if (out_ready) w_state_nxt = w_accept ? S_FULL : S_EMPTY;
        else                w_state_nxt = S_FULL;
      end
      default: w_state_nxt = S_EMPTY;
    endcase
  end

  // Occupancy outputs.
  always_comb begin
    out_valid = (r_state == S_FULL);
  end

  // Output bundle: loads on accept and otherwise holds, so it is stable under backpressure.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pc       <= '0;
      r_rd1      <= '0;
      r_rd2      <= '0;
      r_imm      <= '0;
      r_rd       <= '0;
      r_branch   <= 1'b0;
      r_memread  <= 1'b0;
      r_memtoreg <= 1'b0;
      r_memwrite <= 1'b0;
      r_alusrc   <= 1'b0;
      r_regwrite <= 1'b0;
      r_aluop    <= 4'b0000;
    end else if (w_accept) begin
      r_pc       <= in_pc;
      r_rd1      <= w_rd1;
      r_rd2      <= w_rd2;
      r_imm      <= w_imm;
      r_rd       <= w_rd;
      r_branch   <= w_branch;
      r_memread  <= w_memread;
      r_memtoreg <= w_memtoreg;
      r_memwrite <= w_memwrite;
      r_alusrc   <= w_alusrc;
      r_regwrite <= w_regwrite;
      r_aluop    <= w_aluop;
    end
  end

`ifdef DEC_ILLEGAL_EN
  // Illegal flag travels with its bundle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)        r_illegal <= 1'b0;
    else if (w_accept) r_illegal <= w_illegal;
  end
  assign Illegal = r_illegal;
`endif

  // Shadow keeps a departing load's Rd visible for one more cycle; flush kills it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_shadow_v  <= 1'b0;
      r_shadow_rd <= '0;
    end else if (flush) begin
      r_shadow_v  <= 1'b0;
    end else begin
      r_shadow_v  <= out_valid && out_ready && r_memread;
      r_shadow_rd <= r_rd;
    end
  end

  assign out_pc    = r_pc;
  assign ReadData1 = r_rd1;
  assign ReadData2 = r_rd2;
  assign ImmExt    = r_imm;
  assign Rd        = r_rd;
  assign Branch    = r_branch;
  assign MemRead   = r_memread;
  assign MemtoReg  = r_memtoreg;
  assign MemWrite  = r_memwrite;
  assign ALUSrc    = r_alusrc;
  assign RegWrite  = r_regwrite;
  assign ALUOp     = r_aluop;

endmodule

// File: tb/tb_decode_stage_pipe.sv
// Bench for decode_stage_pipe: decode vector table, directed corner sequences and random traffic
// checked against a reference model built from the decode/pipeline rules.
module tb_decode_stage_pipe;
  localparam int XLEN = 64;
  localparam int NREGS = 32;
  localparam int AW = 5;

`ifdef DEC_ILLEGAL_EN
  localparam bit ILL = 1'b1;
`else
  localparam bit ILL = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic in_valid = 1'b0, in_ready, flush = 1'b0, wb_en = 1'b0, out_valid, out_ready = 1'b0;
  logic [31:0] Instr = 32'h0;
  logic [XLEN-1:0] in_pc = '0, wb_data = '0, out_pc, ReadData1, ReadData2, ImmExt;
  logic [AW-1:0] wb_addr = '0, Rd;
  logic Branch, MemRead, MemtoReg, MemWrite, ALUSrc, RegWrite;
  logic [3:0] ALUOp;
`ifdef DEC_ILLEGAL_EN
  logic Illegal;
`endif

  always #5 clk = ~clk;

  decode_stage_pipe #(.XLEN(XLEN), .NREGS(NREGS)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .Instr(Instr),
    .in_pc(in_pc), .flush(flush), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .ReadData1(ReadData1),
    .ReadData2(ReadData2), .ImmExt(ImmExt), .Rd(Rd), .Branch(Branch), .MemRead(MemRead),
    .MemtoReg(MemtoReg), .MemWrite(MemWrite), .ALUSrc(ALUSrc), .RegWrite(RegWrite),
    .ALUOp(ALUOp)
`ifdef DEC_ILLEGAL_EN
    , .Illegal(Illegal)
`endif
  );

  int n_checks = 0;
  int n_fail = 0;
  bit last_in_ready;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Instruction encoders
  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction
  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd, input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction
  function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2, input logic [4:0] rs1);
    return {imm[11:5], rs2, rs1, 3'b011, imm[4:0], 7'b0100011};
  endfunction
  function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2, input logic [4:0] rs1);
    return {imm[12], imm[10:5], rs2, rs1, 3'b000, imm[4:1], imm[11], 7'b1100011};
  endfunction

  // Reference decode: ctl = {Branch, MemRead, MemtoReg, MemWrite, ALUSrc, RegWrite}
  typedef struct packed {
    logic [5:0]  ctl;
    logic [3:0]  aluop;
    logic [63:0] imm;
    logic [4:0]  rd;
    logic        use1, use2, ill;
  } dec_t;

  function automatic dec_t ref_decode(input logic [31:0] ins);
    dec_t d;
    logic [2:0] f3;
    logic f7b;
    f3 = ins[14:12];
    f7b = ins[30];
    d = '0;
    d.rd = ins[11:7];
    case (ins[6:0])
      7'b0110011: begin
        d.use1 = 1'b1; d.use2 = 1'b1; d.ctl = 6'b000001;
        if (f3 == 3'd0 && !f7b)      d.aluop = 4'b0010;
        else if (f3 == 3'd0 && f7b)  d.aluop = 4'b0110;
        else if (f3 == 3'd7 && !f7b) d.aluop = 4'b0111;
        else if (f3 == 3'd6 && !f7b) d.aluop = 4'b0001;
        else d.ill = 1'b1;
      end
      7'b0010011: begin
        if (f3 == 3'd0) begin
          d.use1 = 1'b1; d.ctl = 6'b000011; d.aluop = 4'b0010;
          d.imm = 64'($signed(ins[31:20]));
        end else d.ill = 1'b1;
      end
      7'b0000011: begin
        d.use1 = 1'b1; d.ctl = 6'b011011; d.aluop = 4'b0010;
        d.imm = 64'($signed(ins[31:20]));
      end
      7'b0100011: begin
        d.use1 = 1'b1; d.use2 = 1'b1; d.ctl = 6'b000110; d.rd = 5'd0;
        d.imm = 64'($signed({ins[31:25], ins[11:7]}));
      end
      7'b1100011: begin
        d.use1 = 1'b1; d.use2 = 1'b1; d.ctl = 6'b100000; d.aluop = 4'b0110; d.rd = 5'd0;
        d.imm = 64'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
      end
      default: d.ill = 1'b1;
    endcase
    if (ILL && d.ill) begin
      d.ctl = 6'b0; d.aluop = 4'b0;
    end
    return d;
  endfunction

  // Reference pipeline state
  typedef struct packed {
    logic [63:0] pc, rd1, rd2;
    dec_t d;
  } bundle_t;

  logic [63:0] m_rf [32];
  bit m_valid, m_sv;
  logic [4:0] m_srd;
  bundle_t m_b;

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_rf[i] = 64'h0;
    m_valid = 1'b0; m_sv = 1'b0; m_srd = 5'd0; m_b = '0;
  endtask

  function automatic logic [63:0] ref_read(input logic [4:0] r);
    if (r == 5'd0) return 64'h0;
    if (wb_en && wb_addr == r) return wb_data;
    return m_rf[r];
  endfunction

  function automatic bit dep(input dec_t d, input logic [31:0] ins, input bit en, input logic [4:0] r);
    return en && (r != 5'd0) && ((d.use1 && ins[19:15] == r) || (d.use2 && ins[24:20] == r));
  endfunction

  // One clock: check DUT against model at the falling edge, advance model, return at posedge+1
  task automatic step();
    dec_t d;
    bit hz, adv, exp_ready, acc, leaving_ld;
    @(negedge clk);
    d = ref_decode(Instr);
    hz = in_valid && (dep(d, Instr, m_valid && m_b.d.ctl[4], m_b.d.rd) || dep(d, Instr, m_sv, m_srd));
    adv = !m_valid || out_ready;
    exp_ready = adv && !hz && !flush;
    acc = in_valid && exp_ready;
    last_in_ready = in_ready;
    chk("in_ready", in_ready, exp_ready);
    chk("out_valid", out_valid, m_valid);
    if (m_valid) begin
      chk("out_pc", out_pc, m_b.pc);
      chk("ReadData1", ReadData1, m_b.rd1);
      chk("ReadData2", ReadData2, m_b.rd2);
      chk("ImmExt", ImmExt, m_b.d.imm);
      chk("Rd", Rd, m_b.d.rd);
      chk("controls", {Branch, MemRead, MemtoReg, MemWrite, ALUSrc, RegWrite}, m_b.d.ctl);
      chk("ALUOp", ALUOp, m_b.d.aluop);
`ifdef DEC_ILLEGAL_EN
      chk("Illegal", Illegal, m_b.d.ill);
`endif
    end
    leaving_ld = m_valid && out_ready && m_b.d.ctl[4];
    if (flush) begin
      m_valid = 1'b0; m_sv = 1'b0;
    end else begin
      m_sv = leaving_ld; m_srd = m_b.d.rd;
      if (acc) begin
        m_b.pc = in_pc; m_b.rd1 = ref_read(Instr[19:15]); m_b.rd2 = ref_read(Instr[24:20]); m_b.d = d;
        m_valid = 1'b1;
      end else if (adv) m_valid = 1'b0;
    end
    if (wb_en && wb_addr != 5'd0) m_rf[wb_addr] = wb_data;
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic [31:0] instr;
    logic [63:0] imm;
    logic [5:0]  ctl;
    logic [3:0]  aluop;
    logic [4:0]  rd;
    logic        ill;
  } vec_t;

  function automatic logic [31:0] rand_instr();
    logic [4:0] a, b, c;
    a = 5'($urandom_range(0, 7)); b = 5'($urandom_range(0, 7)); c = 5'($urandom_range(0, 7));
    case ($urandom_range(0, 9))
      0: return enc_r(7'b0000000, b, a, 3'b000, c);
      1: return enc_r(7'b0100000, b, a, 3'b000, c);
      2: return enc_r(7'b0000000, b, a, 3'b111, c);
      3: return enc_r(7'b0000000, b, a, 3'b110, c);
      4: return enc_i(12'($urandom), a, 3'b000, c, 7'b0010011);
      5: return enc_i(12'($urandom), a, 3'b011, c, 7'b0000011);
      6: return enc_s(12'($urandom), b, a);
      7: return enc_b({12'($urandom), 1'b0}, b, a);
      8: return enc_r({1'b0, 1'($urandom), 5'b0}, b, a, 3'($urandom), c);
      default: return 32'($urandom);
    endcase
  endfunction

  initial begin
    vec_t tbl [12];
    int cnt;
    bit got;

    tbl[0]  = '{enc_r(7'b0000000, 5'd2, 5'd1, 3'b000, 5'd4), 64'h0, 6'b000001, 4'b0010, 5'd4, 1'b0};
    tbl[1]  = '{enc_r(7'b0100000, 5'd2, 5'd1, 3'b000, 5'd5), 64'h0, 6'b000001, 4'b0110, 5'd5, 1'b0};
    tbl[2]  = '{enc_r(7'b0000000, 5'd2, 5'd1, 3'b111, 5'd6), 64'h0, 6'b000001, 4'b0111, 5'd6, 1'b0};
    tbl[3]  = '{enc_r(7'b0000000, 5'd2, 5'd1, 3'b110, 5'd7), 64'h0, 6'b000001, 4'b0001, 5'd7, 1'b0};
    tbl[4]  = '{enc_i(12'hFFB, 5'd1, 3'b000, 5'd8, 7'b0010011), 64'hFFFF_FFFF_FFFF_FFFB, 6'b000011, 4'b0010, 5'd8, 1'b0};
    tbl[5]  = '{enc_i(12'd8, 5'd1, 3'b011, 5'd9, 7'b0000011), 64'h8, 6'b011011, 4'b0010, 5'd9, 1'b0};
    tbl[6]  = '{enc_s(12'hFFC, 5'd2, 5'd1), 64'hFFFF_FFFF_FFFF_FFFC, 6'b000110, 4'b0000, 5'd0, 1'b0};
    tbl[7]  = '{enc_b(13'h1FF8, 5'd2, 5'd1), 64'hFFFF_FFFF_FFFF_FFF8, 6'b100000, 4'b0110, 5'd0, 1'b0};
    tbl[8]  = '{enc_b(13'h0FFE, 5'd2, 5'd1), 64'h0000_0000_0000_0FFE, 6'b100000, 4'b0110, 5'd0, 1'b0};
    tbl[9]  = '{32'h0000_0537, 64'h0, 6'b000000, 4'b0000, 5'd10, 1'b1};
    tbl[10] = '{enc_r(7'b0000000, 5'd2, 5'd1, 3'b100, 5'd11), 64'h0, ILL ? 6'b000000 : 6'b000001, 4'b0000, 5'd11, 1'b1};
    tbl[11] = '{enc_i(12'd3, 5'd1, 3'b010, 5'd12, 7'b0010011), 64'h0, 6'b000000, 4'b0000, 5'd12, 1'b1};

    model_reset();
    #12;
    chk("reset out_valid", out_valid, 1'b0);
    chk("reset RegWrite", RegWrite, 1'b0);
    chk("reset ALUOp", ALUOp, 4'b0);
    chk("reset ImmExt", ImmExt, 64'h0);
    chk("reset ReadData1", ReadData1, 64'h0);
    #11 reset = 1'b1;
    @(posedge clk); #1;

    // Preload the register file through the write port
    wb_en = 1'b1;
    for (int r = 1; r < 32; r++) begin
      wb_addr = 5'(r); wb_data = {32'($urandom), 32'($urandom)} | 64'h1;
      step();
    end
    wb_en = 1'b0;

    // Decode vector table
    out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      in_valid = 1'b1; Instr = tbl[i].instr; in_pc = 64'h1000 + 64'(i * 4);
      step();
      in_valid = 1'b0;
      chk("vec out_valid", out_valid, 1'b1);
      chk("vec ImmExt", ImmExt, tbl[i].imm);
      chk("vec controls", {Branch, MemRead, MemtoReg, MemWrite, ALUSrc, RegWrite}, tbl[i].ctl);
      chk("vec ALUOp", ALUOp, tbl[i].aluop);
      chk("vec Rd", Rd, tbl[i].rd);
      chk("vec out_pc", out_pc, 64'h1000 + 64'(i * 4));
`ifdef DEC_ILLEGAL_EN
      chk("vec Illegal", Illegal, tbl[i].ill);
`endif
      step();
    end

    // Same-cycle writeback bypass
    wb_en = 1'b1; wb_addr = 5'd3; wb_data = 64'h1234;
    in_valid = 1'b1; Instr = enc_r(7'b0, 5'd3, 5'd3, 3'b000, 5'd4);
    step();
    wb_en = 1'b0; in_valid = 1'b0;
    chk("bypass rs1", ReadData1, 64'h1234);
    chk("bypass rs2", ReadData2, 64'h1234);
    step();

    // Load-use: ld x5,8(x1) then add x6,x5,x2
    in_valid = 1'b1; Instr = enc_i(12'd8, 5'd1, 3'b011, 5'd5, 7'b0000011);
    step();
    chk("ld accepted", last_in_ready, 1'b1);
    Instr = enc_r(7'b0, 5'd2, 5'd5, 3'b000, 5'd6);
    cnt = 0; got = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step();
      if (last_in_ready) begin got = 1'b1; break; end
      cnt++;
    end
    chk("ld-use accepted", got, 1'b1);
    chk("ld-use stall cycles", cnt, 2);
    chk("ld-use add Rd", Rd, 5'd6);
    in_valid = 1'b0;
    step();

    // Backpressure: bundle stable while out_ready low
    out_ready = 1'b0; in_valid = 1'b1; Instr = enc_i(12'd100, 5'd1, 3'b000, 5'd8, 7'b0010011);
    step();
    Instr = enc_r(7'b0, 5'd2, 5'd1, 3'b110, 5'd7);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("stall in_ready", last_in_ready, 1'b0);
      chk("stall out_valid", out_valid, 1'b1);
      chk("stall ImmExt", ImmExt, 64'd100);
      chk("stall Rd", Rd, 5'd8);
    end
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    chk("drain out_valid", out_valid, 1'b0);

    // Flush with a load in the out register
    out_ready = 1'b0; in_valid = 1'b1; Instr = enc_i(12'd8, 5'd1, 3'b011, 5'd5, 7'b0000011);
    step();
    in_valid = 1'b0; flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush out_valid", out_valid, 1'b0);
    in_valid = 1'b1; out_ready = 1'b1; Instr = enc_r(7'b0, 5'd2, 5'd5, 3'b000, 5'd6);
    step();
    chk("no stall after flush", last_in_ready, 1'b1);
    in_valid = 1'b0;
    step();

    // Random traffic against the model
    for (int k = 0; k < 600; k++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      Instr = rand_instr();
      in_pc = {32'($urandom), 32'($urandom)};
      out_ready = ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 15) == 0);
      wb_en = 1'($urandom);
      wb_addr = 5'($urandom_range(0, 7));
      wb_data = {32'($urandom), 32'($urandom)};
      step();
    end
    in_valid = 1'b0; flush = 1'b0; wb_en = 1'b0; out_ready = 1'b0;
    step();

    // Asynchronous reset mid-stream, then x5 must read 0
    wb_en = 1'b1; wb_addr = 5'd5; wb_data = 64'hDEAD;
    in_valid = 1'b1; Instr = enc_i(12'd8, 5'd1, 3'b011, 5'd5, 7'b0000011);
    step();
    wb_en = 1'b0; in_valid = 1'b0;
    chk("pre-reset out_valid", out_valid, 1'b1);
    #2 reset = 1'b0;
    #1;
    chk("async reset out_valid", out_valid, 1'b0);
    chk("async reset MemRead", MemRead, 1'b0);
    chk("async reset RegWrite", RegWrite, 1'b0);
    chk("async reset ALUOp", ALUOp, 4'b0);
    model_reset();
    @(negedge clk); #1 reset = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b1; out_ready = 1'b1; Instr = enc_r(7'b0, 5'd0, 5'd5, 3'b000, 5'd7);
    step();
    in_valid = 1'b0;
    chk("x5 after reset", ReadData1, 64'h0);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
